// File: rtl/dec3to8_two.sv
// Enable-gated 3-to-8 one-hot decoder from two 2-to-4 halves, with sticky hit mask.
// Define DEC3TO8_TWO_REG_OUT_EN to register y/y_valid (1-cycle latency); default is combinational.
module dec3to8_two (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] w,
   input  logic       en,
   input  logic       hit_clr,
   output logic [7:0] y,
   output logic       y_valid,
   output logic [7:0] hit_mask
);

   logic       en_lo;
   logic       en_hi;
   logic [3:0] dec2;
   logic [3:0] line_lo;
   logic [3:0] line_hi;
   logic [7:0] y_d;
   logic [7:0] hit_mask_d;
   logic [7:0] hit_mask_q;

   // Gating by en with AND keeps an undriven w from reaching y while disabled.
   always_comb begin
      en_lo      = en & ~w[2];
      en_hi      = en & w[2];
      dec2       = 4'b0001 << w[1:0];
      line_lo    = {4{en_lo}} & dec2;
      line_hi    = {4{en_hi}} & dec2;
      y_d        = {line_hi, line_lo};
      hit_mask_d = hit_clr ? y_d : (hit_mask_q | y_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_mask_q <= 8'h00;
      end else begin
         hit_mask_q <= hit_mask_d;
      end
   end

   assign hit_mask = hit_mask_q;

`ifdef DEC3TO8_TWO_REG_OUT_EN
   logic [7:0] y_q;
   logic       y_valid_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q       <= 8'h00;
         y_valid_q <= 1'b0;
      end else begin
         y_q       <= y_d;
         y_valid_q <= en;
      end
   end

   assign y       = y_q;
   assign y_valid = y_valid_q;
`else
   assign y       = y_d;
   assign y_valid = en;
`endif

endmodule

// File: tb/tb_dec3to8_two.sv
// Scoreboard bench for dec3to8_two; follows DEC3TO8_TWO_REG_OUT_EN for output latency.
module tb_dec3to8_two;

`ifdef DEC3TO8_TWO_REG_OUT_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 0;
`endif

   typedef struct packed {
      logic [7:0] y;
      logic       v;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic [2:0] w;
   logic       en;
   logic       hit_clr;
   logic [7:0] y;
   logic       y_valid;
   logic [7:0] hit_mask;

   exp_t       exp_q[$];
   logic [7:0] hit_m;
   logic       cur_en;
   logic [2:0] cur_w;
   logic       cur_clr;
   int         n_vec;
   int         n_err;

   dec3to8_two u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .w        (w),
      .en       (en),
      .hit_clr  (hit_clr),
      .y        (y),
      .y_valid  (y_valid),
      .hit_mask (hit_mask)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] ref_dec(input logic e, input logic [2:0] ww);
      logic [7:0] r;
      r = 8'h00;
      if (e) r[ww] = 1'b1;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   // Queue the expectation for the inputs currently on the pins.
   task automatic seed();
      exp_t e;
      exp_q.delete();
      if (LAT == 1) begin
         e.y = ref_dec(cur_en, cur_w);
         e.v = cur_en;
         exp_q.push_back(e);
      end
   endtask

   task automatic cyc(input logic e_i, input logic [2:0] w_i, input logic c_i);
      exp_t e;
      exp_t got;
      @(posedge clk);
      #1;
      hit_m   = cur_clr ? ref_dec(cur_en, cur_w) : (hit_m | ref_dec(cur_en, cur_w));
      en      = e_i;
      w       = w_i;
      hit_clr = c_i;
      cur_en  = e_i;
      cur_w   = w_i;
      cur_clr = c_i;
      e.y     = ref_dec(e_i, w_i);
      e.v     = e_i;
      exp_q.push_back(e);
      @(negedge clk);
      chk("hit_mask", hit_mask, hit_m);
      if (exp_q.size() > LAT) begin
         got = exp_q.pop_front();
         chk("y", y, got.y);
         chk("y_valid", {7'd0, y_valid}, {7'd0, got.v});
         if (got.v) chk("onehot", 8'($countones(y)), 8'd1);
      end
   endtask

   initial begin
      n_vec   = 0;
      n_err   = 0;
      hit_m   = 8'h00;
      rst_n   = 1'b0;
      en      = 1'b0;
      w       = 3'd0;
      hit_clr = 1'b0;
      cur_en  = 1'b0;
      cur_w   = 3'd0;
      cur_clr = 1'b0;

      #12;
      chk("rst_y", y, 8'h00);
      chk("rst_valid", {7'd0, y_valid}, 8'h00);
      chk("rst_hit", hit_mask, 8'h00);
      rst_n = 1'b1;
      seed();

      cyc(1'b0, 3'b000, 1'b0);
      cyc(1'b0, 3'b101, 1'b0);
      cyc(1'b0, 3'b111, 1'b0);

      for (int i = 0; i < 8; i++) cyc(1'b1, 3'(i), 1'b0);

      cyc(1'b0, 3'b010, 1'b0);
      cyc(1'b0, 3'b010, 1'b0);
      chk("hit_full", hit_mask, 8'hFF);

      cyc(1'b1, 3'b011, 1'b1);
      cyc(1'b1, 3'b001, 1'b0);
      chk("hit_after_clr", hit_mask, 8'h08);
      cyc(1'b1, 3'b110, 1'b0);
      chk("hit_accum", hit_mask, 8'h0A);

      for (int i = 0; i < 8; i++) cyc(1'b1, (i % 2 == 0) ? 3'b011 : 3'b100, 1'b0);

      cyc(1'b1, 3'b110, 1'b0);
      cyc(1'b1, 3'b110, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_y", y, (LAT == 1) ? 8'h00 : 8'h40);
      chk("mid_rst_valid", {7'd0, y_valid}, (LAT == 1) ? 8'h00 : 8'h01);
      chk("mid_rst_hit", hit_mask, 8'h00);
      hit_m = 8'h00;
      @(negedge clk);
      chk("held_rst_hit", hit_mask, 8'h00);
      #2;
      rst_n = 1'b1;
      seed();
      cyc(1'b1, 3'b110, 1'b0);
      chk("post_rst_hit", hit_mask, 8'h40);

      for (int i = 0; i < 24; i++)
         cyc(1'($urandom_range(1, 0)), 3'($urandom_range(7, 0)), ($urandom_range(7, 0) == 0));
      cyc(1'b0, 3'b000, 1'b0);
      cyc(1'b0, 3'b000, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
